// File: rtl/cpu_run_controller_if.sv
// ============================================================
// cpu_run_controller_if: button, halt and status bundle for the run controller
// Rev 1.0
// ============================================================
`default_nettype none

interface cpu_run_controller_if #(
    parameter int NBTN  = 2,
    parameter int CYC_W = 32
);
    logic [NBTN-1:0]  btn_in;
    logic             cpu_halt;
    logic [NBTN-1:0]  btn_level;
    logic [NBTN-1:0]  btn_pulse;
    logic             cpu_rst;
    logic             cpu_run;
    logic [CYC_W-1:0] cycle_count;
    logic [2:0]       state;
    logic             done;
    logic             timed_out;

    modport master (
        output btn_in, cpu_halt,
        input  btn_level, btn_pulse, cpu_rst, cpu_run, cycle_count, state, done, timed_out
    );

    modport slave (
        input  btn_in, cpu_halt,
        output btn_level, btn_pulse, cpu_rst, cpu_run, cycle_count, state, done, timed_out
    );
endinterface

`default_nettype wire

// File: rtl/cpu_run_controller.sv
// ============================================================
// cpu_run_controller: debounces front-panel buttons, sequences CPU reset/run
// Rev 1.0
// ============================================================
`default_nettype none

module cpu_run_controller #(
    parameter int NBTN             = 2,
    parameter int DEBOUNCE_CYCLES  = 4,
    parameter int CPU_RESET_CYCLES = 3,
    parameter int CYC_W            = 32,
    parameter int TIMEOUT          = 0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    cpu_run_controller_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_RESET    = 3'd0,
        ST_READY    = 3'd1,
        ST_RUN      = 3'd2,
        ST_HALTED   = 3'd3,
        ST_TIMEDOUT = 3'd4
    } state_t;

    localparam int               DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int               RC_W    = $clog2(CPU_RESET_CYCLES + 1);
    localparam logic [DB_W-1:0]  DB_MAX  = DB_W'(DEBOUNCE_CYCLES);
    localparam logic [RC_W-1:0]  RC_LAST = RC_W'(CPU_RESET_CYCLES - 1);
    localparam logic [CYC_W-1:0] TO_LAST = CYC_W'(TIMEOUT - 1);
    localparam bit               TO_EN   = (TIMEOUT != 0);

    logic [NBTN-1:0] level_vec;
    logic [NBTN-1:0] pulse_vec;

    generate
        for (genvar i = 0; i < NBTN; i++) begin : g_btn
            logic            sync1;
            logic            sync2;
            logic            level;
            logic            pulse;
            logic [DB_W-1:0] db_cnt;

            // Level only flips after the synchronised input has disagreed for
            // DEBOUNCE_CYCLES+1 consecutive samples; any agreement restarts the count.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    sync1  <= 1'b0;
                    sync2  <= 1'b0;
                    level  <= 1'b0;
                    pulse  <= 1'b0;
                    db_cnt <= '0;
                end else begin
                    sync1 <= bus.btn_in[i];
                    sync2 <= sync1;
                    pulse <= 1'b0;
                    if (sync2 == level) begin
                        db_cnt <= '0;
                    end else if (db_cnt == DB_MAX) begin
                        db_cnt <= '0;
                        level  <= sync2;
                        pulse  <= sync2;
                    end else begin
                        db_cnt <= db_cnt + 1'b1;
                    end
                end
            end

            assign level_vec[i] = level;
            assign pulse_vec[i] = pulse;
        end
    endgenerate

    state_t           state_q, state_d;
    logic [RC_W-1:0]  rst_cnt_q, rst_cnt_d;
    logic [CYC_W-1:0] cyc_q, cyc_d;
    logic             cpu_rst_q, cpu_run_q, done_q, timed_out_q;

    always_comb begin
        state_d   = state_q;
        rst_cnt_d = rst_cnt_q;
        cyc_d     = cyc_q;
        if (pulse_vec[0]) begin
            state_d   = ST_RESET;
            rst_cnt_d = '0;
        end else begin
            case (state_q)
                ST_RESET: begin
                    if (rst_cnt_q == RC_LAST) state_d = ST_READY;
                    else                      rst_cnt_d = rst_cnt_q + 1'b1;
                end
                ST_READY: begin
                    if (pulse_vec[1]) begin
                        state_d = ST_RUN;
                        cyc_d   = '0;
                    end
                end
                ST_RUN: begin
                    // The halting cycle is not counted; the timeout cycle is.
                    if (bus.cpu_halt) begin
                        state_d = ST_HALTED;
                    end else begin
                        if (cyc_q != '1) cyc_d = cyc_q + 1'b1;
                        if (TO_EN && (cyc_q == TO_LAST)) state_d = ST_TIMEDOUT;
                    end
                end
                ST_HALTED, ST_TIMEDOUT: ;
                default: begin
                    state_d   = ST_RESET;
                    rst_cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_RESET;
            rst_cnt_q   <= '0;
            cyc_q       <= '0;
            cpu_rst_q   <= 1'b1;
            cpu_run_q   <= 1'b0;
            done_q      <= 1'b0;
            timed_out_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rst_cnt_q   <= rst_cnt_d;
            cyc_q       <= cyc_d;
            cpu_rst_q   <= (state_d == ST_RESET);
            cpu_run_q   <= (state_d == ST_RUN);
            done_q      <= (state_d == ST_HALTED) || (state_d == ST_TIMEDOUT);
            timed_out_q <= (state_d == ST_TIMEDOUT);
        end
    end

    assign bus.btn_level   = level_vec;
    assign bus.btn_pulse   = pulse_vec;
    assign bus.cpu_rst     = cpu_rst_q;
    assign bus.cpu_run     = cpu_run_q;
    assign bus.cycle_count = cyc_q;
    assign bus.state       = state_q;
    assign bus.done        = done_q;
    assign bus.timed_out   = timed_out_q;

endmodule

`default_nettype wire

// File: tb/tb_cpu_run_controller.sv
// ============================================================
// tb_cpu_run_controller: three parameterisations driven in lockstep, scoreboard checked
// Rev 1.0
// ============================================================
`default_nettype none

module tb_cpu_run_controller;

    localparam int F_STATE = 0;
    localparam int F_RST   = 1;
    localparam int F_RUN   = 2;
    localparam int F_CNT   = 3;
    localparam int F_DONE  = 4;
    localparam int F_TO    = 5;
    localparam int F_LVL   = 6;
    localparam int F_PLS   = 7;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [1:0] btn;
    logic       halt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    // A: no timeout, wide counter. B: timeout 50. C: 4-bit saturating counter.
    cpu_run_controller_if #(.NBTN(2), .CYC_W(32)) bus_a ();
    cpu_run_controller_if #(.NBTN(2), .CYC_W(32)) bus_b ();
    cpu_run_controller_if #(.NBTN(2), .CYC_W(4))  bus_c ();

    assign bus_a.btn_in = btn;  assign bus_a.cpu_halt = halt;
    assign bus_b.btn_in = btn;  assign bus_b.cpu_halt = halt;
    assign bus_c.btn_in = btn;  assign bus_c.cpu_halt = halt;

    cpu_run_controller #(.NBTN(2), .DEBOUNCE_CYCLES(4), .CPU_RESET_CYCLES(3), .CYC_W(32), .TIMEOUT(0))
        dut_a (.clk(clk), .reset_n(reset_n), .bus(bus_a));
    cpu_run_controller #(.NBTN(2), .DEBOUNCE_CYCLES(4), .CPU_RESET_CYCLES(3), .CYC_W(32), .TIMEOUT(50))
        dut_b (.clk(clk), .reset_n(reset_n), .bus(bus_b));
    cpu_run_controller #(.NBTN(2), .DEBOUNCE_CYCLES(4), .CPU_RESET_CYCLES(3), .CYC_W(4), .TIMEOUT(0))
        dut_c (.clk(clk), .reset_n(reset_n), .bus(bus_c));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] observe(input int sel);
        logic [31:0] v [8];
        case (sel / 8)
            0: v = '{32'(bus_a.state), 32'(bus_a.cpu_rst), 32'(bus_a.cpu_run), 32'(bus_a.cycle_count),
                     32'(bus_a.done), 32'(bus_a.timed_out), 32'(bus_a.btn_level), 32'(bus_a.btn_pulse)};
            1: v = '{32'(bus_b.state), 32'(bus_b.cpu_rst), 32'(bus_b.cpu_run), 32'(bus_b.cycle_count),
                     32'(bus_b.done), 32'(bus_b.timed_out), 32'(bus_b.btn_level), 32'(bus_b.btn_pulse)};
            default: v = '{32'(bus_c.state), 32'(bus_c.cpu_rst), 32'(bus_c.cpu_run), 32'(bus_c.cycle_count),
                     32'(bus_c.done), 32'(bus_c.timed_out), 32'(bus_c.btn_level), 32'(bus_c.btn_pulse)};
        endcase
        return v[sel % 8];
    endfunction

    task automatic expect_one(input string tag, input int d, input int f, input logic [31:0] v);
        exp_t e;
        e.tag = $sformatf("%s.%s", tag, (d == 0) ? "a" : (d == 1) ? "b" : "c");
        e.sel = d * 8 + f;
        e.exp = v;
        sb.push_back(e);
    endtask

    task automatic expect_all(input string tag, input int f, input logic [31:0] v);
        for (int d = 0; d < 3; d++) expect_one(tag, d, f, v);
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.tag, observe(e.sel), e.exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        btn     = 2'b00;
        halt    = 1'b0;
        repeat (5) @(negedge clk);
        expect_all("por_state", F_STATE, 0);
        expect_all("por_rst",   F_RST,   1);
        expect_all("por_run",   F_RUN,   0);
        drain();

        reset_n = 1'b1;
        for (int n = 1; n <= 3; n++) begin
            @(negedge clk);
            expect_all("rel_rst",   F_RST,   (n < 3));
            expect_all("rel_state", F_STATE, (n < 3) ? 0 : 1);
            drain();
        end
        expect_all("idle_run",  F_RUN,  0);
        expect_all("idle_cnt",  F_CNT,  0);
        expect_all("idle_done", F_DONE, 0);
        expect_all("idle_to",   F_TO,   0);
        expect_all("idle_lvl",  F_LVL,  0);
        expect_all("idle_pls",  F_PLS,  0);
        drain();

        // Three-cycle glitch on start must be filtered out
        btn = 2'b10;
        repeat (3) @(negedge clk);
        btn = 2'b00;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            expect_one("glitch_lvl", 0, F_LVL, 0);
            expect_one("glitch_pls", 0, F_PLS, 0);
            expect_one("glitch_state", 0, F_STATE, 1);
            drain();
        end

        // Long press: level rises 6 edges after first sample, run starts one edge later
        btn = 2'b10;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            expect_all("press_lvl",   F_LVL,   (n >= 7) ? 2 : 0);
            expect_all("press_pls",   F_PLS,   (n == 7) ? 2 : 0);
            expect_all("press_state", F_STATE, (n >= 8) ? 2 : 1);
            expect_all("press_run",   F_RUN,   (n >= 8));
            if (n >= 8) expect_all("press_cnt", F_CNT, n - 8);
            drain();
            if (n == 10) btn = 2'b00;
        end

        for (int m = 3; m <= 100; m++) begin
            @(negedge clk);
            expect_one("run_cnt",   0, F_CNT,   m);
            expect_one("run_state", 0, F_STATE, 2);
            expect_one("sat_cnt",   2, F_CNT,   (m < 15) ? m : 15);
            expect_one("sat_state", 2, F_STATE, 2);
            expect_one("to_cnt",    1, F_CNT,   (m < 50) ? m : 50);
            expect_one("to_state",  1, F_STATE, (m < 50) ? 2 : 4);
            if (m == 50 || m == 51) begin
                expect_one("to_flag", 1, F_TO,   1);
                expect_one("to_done", 1, F_DONE, 1);
                expect_one("to_run",  1, F_RUN,  0);
            end
            if (m == 8)  expect_one("rel_lvl_hi", 0, F_LVL, 2);
            if (m == 9) begin
                expect_one("fall_lvl", 0, F_LVL, 0);
                expect_one("fall_pls", 0, F_PLS, 0);
            end
            if (m == 66) expect_one("rp_lvl_lo", 0, F_LVL, 0);
            if (m == 67) begin
                expect_one("rp_lvl", 0, F_LVL, 2);
                expect_one("rp_pls", 0, F_PLS, 2);
            end
            if (m == 68) expect_one("rp_pls_end", 0, F_PLS, 0);
            if (m == 76) expect_one("rp_lvl_hold", 0, F_LVL, 2);
            if (m == 77) begin
                expect_one("rp_fall_lvl", 0, F_LVL, 0);
                expect_one("rp_fall_pls", 0, F_PLS, 0);
            end
            drain();
            if (m == 60) btn = 2'b10;
            if (m == 70) btn = 2'b00;
            if (m == 100) halt = 1'b1;
        end

        for (int n = 1; n <= 2; n++) begin
            @(negedge clk);
            expect_one("halt_state", 0, F_STATE, 3);
            expect_one("halt_done",  0, F_DONE,  1);
            expect_one("halt_run",   0, F_RUN,   0);
            expect_one("halt_cnt",   0, F_CNT,   100);
            expect_one("halt_to",    0, F_TO,    0);
            expect_one("halt_b_state", 1, F_STATE, 4);
            expect_one("halt_b_cnt",   1, F_CNT,   50);
            expect_one("halt_c_state", 2, F_STATE, 3);
            expect_one("halt_c_cnt",   2, F_CNT,   15);
            drain();
        end
        halt = 1'b0;

        // Reset button from HALTED / TIMEDOUT; counts held through RESET
        btn = 2'b01;
        for (int n = 1; n <= 11; n++) begin
            @(negedge clk);
            if (n == 7) begin
                expect_all("rb_pls", F_PLS, 1);
                expect_one("rb_pre_state", 0, F_STATE, 3);
            end
            if (n >= 8 && n <= 10) begin
                expect_all("rb_state", F_STATE, 0);
                expect_all("rb_rst",   F_RST,   1);
                expect_all("rb_done",  F_DONE,  0);
                expect_all("rb_to",    F_TO,    0);
                expect_one("rb_cnt_a", 0, F_CNT, 100);
                expect_one("rb_cnt_b", 1, F_CNT, 50);
                expect_one("rb_cnt_c", 2, F_CNT, 15);
            end
            if (n == 11) begin
                expect_all("rb_state", F_STATE, 1);
                expect_all("rb_rst",   F_RST,   0);
            end
            drain();
            if (n == 8) btn = 2'b00;
        end

        btn = 2'b10;
        for (int n = 1; n <= 13; n++) begin
            @(negedge clk);
            if (n == 8) begin
                expect_all("st2_state", F_STATE, 2);
                expect_all("st2_cnt",   F_CNT,   0);
                expect_all("st2_run",   F_RUN,   1);
            end
            if (n == 13) expect_all("st2_cnt", F_CNT, 5);
            drain();
            if (n == 8) btn = 2'b00;
        end

        // Reset pulse and halt in the same cycle: reset wins
        btn = 2'b01;
        for (int n = 1; n <= 11; n++) begin
            @(negedge clk);
            if (n <= 7) expect_all("sim_cnt", F_CNT, 5 + n);
            if (n == 7) begin
                expect_all("sim_pls",   F_PLS,   1);
                expect_all("sim_state", F_STATE, 2);
            end
            if (n >= 8 && n <= 10) begin
                expect_all("sim_state", F_STATE, 0);
                expect_all("sim_rst",   F_RST,   1);
                expect_all("sim_run",   F_RUN,   0);
                expect_all("sim_done",  F_DONE,  0);
                expect_all("sim_cnt",   F_CNT,   12);
            end
            if (n == 11) begin
                expect_all("sim_state", F_STATE, 1);
                expect_all("sim_rst",   F_RST,   0);
            end
            drain();
            if (n == 7) halt = 1'b1;
            if (n == 8) begin
                btn  = 2'b00;
                halt = 1'b0;
            end
        end

        btn = 2'b10;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            if (n == 12) begin
                expect_all("ar_pre_state", F_STATE, 2);
                expect_all("ar_pre_cnt",   F_CNT,   4);
            end
            drain();
            if (n == 8) btn = 2'b00;
        end

        // Asynchronous reset mid-run, checked before the next clock edge
        #2 reset_n = 1'b0;
        #1;
        expect_all("ar_state", F_STATE, 0);
        expect_all("ar_rst",   F_RST,   1);
        expect_all("ar_run",   F_RUN,   0);
        expect_all("ar_cnt",   F_CNT,   0);
        expect_all("ar_done",  F_DONE,  0);
        expect_all("ar_lvl",   F_LVL,   0);
        expect_all("ar_pls",   F_PLS,   0);
        drain();

        @(negedge clk);
        reset_n = 1'b1;
        for (int n = 1; n <= 3; n++) begin
            @(negedge clk);
            expect_all("ar_rel_rst", F_RST, (n < 3));
            drain();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/cpu_run_controller.md
# cpu_run_controller

Parametrised front-panel run controller for the integrated CPU. It conditions raw push-button inputs and sequences the CPU core's reset and start, replacing hand-driven reset/start stimulus with synthesizable logic. It counts execution cycles from start until the core signals halt, with an optional cycle timeout. It sits between the board buttons/LEDs and the CPU core reset/run inputs.

## Interface
- NBTN, 2: number of button channels (min 2; ch0 = reset request, ch1 = start request, rest pass-through)
- DEBOUNCE_CYCLES, 4: consecutive stable cycles required to accept a button change (≥1)
- CPU_RESET_CYCLES, 3: cycles cpu_rst is held high per reset sequence (≥1)
- CYC_W, 32: cycle counter width
- TIMEOUT, 0: max RUN cycles before forced stop; 0 disables

- clk  in  1  system clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- btn_in  in  NBTN  raw, asynchronous button levels (active-high)
- cpu_halt  in  1  CPU halt indication (active-high, level)
- btn_level  out  NBTN  debounced button levels
- btn_pulse  out  NBTN  one-cycle pulse per debounced rising edge
- cpu_rst  out  1  active-high reset to CPU core
- cpu_run  out  1  CPU enable, high only in RUN
- cycle_count  out  CYC_W  cycles spent in RUN since last start
- state  out  3  FSM state encoding (RESET=0, READY=1, RUN=2, HALTED=3, TIMEDOUT=4)
- done  out  1  high in HALTED or TIMEDOUT
- timed_out  out  1  high in TIMEDOUT only

## Operation
- Reset (reset_n low, async): state=RESET, reset counter=0, cpu_rst=1, cpu_run=0, cycle_count=0, btn_level=0, btn_pulse=0, done=0, timed_out=0, sync/debounce counters cleared.
- Input path per channel: 2-FF synchroniser → debounce counter. Counter increments while synchronised value ≠ btn_level, clears when equal; when it reaches DEBOUNCE_CYCLES, btn_level takes the synchronised value and counter clears.
- btn_pulse[i] high for exactly one cycle, the first cycle btn_level[i] is 1. Falling edges produce no pulse.
- FSM:
  - RESET: cpu_rst=1; counts cycles; after CPU_RESET_CYCLES cycles in RESET → READY.
  - READY: cpu_rst=0; btn_pulse[1] → RUN, cycle_count cleared to 0 on entry.
  - RUN: cpu_run=1; cycle_count +1 per cycle, saturating at all-ones. cpu_halt=1 → HALTED. If TIMEOUT≠0 and cycle_count==TIMEOUT-1 (before increment) → TIMEDOUT.
  - HALTED / TIMEDOUT: cpu_run=0, cycle_count frozen, done=1.
  - btn_pulse[0] in any state → RESET (reset counter cleared, cycle_count held until next start).
- Priorities (same cycle): btn_pulse[0] > cpu_halt > timeout > btn_pulse[1]. Start in RUN/HALTED/TIMEDOUT ignored; re-run requires reset.
- cycle_count counts cycles with cpu_run=1: a program halting after N enabled cycles reports N.

## Timing
- All outputs registered; state-derived outputs change on the edge the state changes.
- Button latency: new raw level stable from edge k → btn_level/btn_pulse change at edge k+2+DEBOUNCE_CYCLES.
- Glitch shorter than DEBOUNCE_CYCLES synchronised cycles: no change on btn_level.
- reset_n deassert → cpu_rst falls exactly CPU_RESET_CYCLES edges later.
- READY + btn_pulse[1] at edge t → cpu_run=1 after edge t; cpu_halt sampled high at edge h → cpu_run=0 after edge h, that cycle not counted.
- reset_n asserted mid-RUN: immediate async return to RESET, cpu_run=0, cpu_rst=1.

## Test plan
- Power-on: reset_n low 5 cycles, release → cpu_rst high 3 cycles then 0, state=1, all other outputs 0.
- Debounce (DEBOUNCE_CYCLES=4): btn_in[1] high 3 cycles → no btn_level change; high 10 cycles → btn_level[1] rises 6 edges after first sample, btn_pulse[1] exactly 1 cycle.
- Normal run: start from READY, assert cpu_halt after 100 cpu_run cycles → state=3, done=1, cycle_count=100, cpu_run=0.
- Timeout (TIMEOUT=50): start, never halt → state=4, timed_out=1, cycle_count=50, cpu_run=0.
- Simultaneous: btn_pulse[0] and cpu_halt same cycle in RUN → RESET, cpu_rst high 3 cycles; btn_pulse[1] while RUN → ignored, count continues.
- Saturation (CYC_W=4, TIMEOUT=0): run 20 cycles → cycle_count holds 15; reset_n pulse mid-run → all outputs to reset values immediately.
